// File: rtl/sound_pkg.sv
// Shared constants and state encoding for the sound mixer and its helpers.
package sound_pkg;

    localparam int SAMPLE_W   = 8;
    localparam int GAIN_W     = 4;
    localparam int SAMPLE_MAX = 127;
    localparam int SAMPLE_MIN = -128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } mix_state_t;

    function automatic int sample_max(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

    function automatic int sample_min(input int width);
        return -(1 << (width - 1));
    endfunction

endpackage

// File: rtl/sound_sat.sv
// Clamps a wide signed accumulator into a signed sample and flags when clamping occurred.
module sound_sat
    import sound_pkg::*;
#(
    parameter int ACC_W    = 11,
    parameter int SAMPLE_W = 8,
    parameter int MAX_VAL  = SAMPLE_MAX,
    parameter int MIN_VAL  = SAMPLE_MIN
) (
    input  logic signed [ACC_W-1:0]    acc,
    output logic signed [SAMPLE_W-1:0] sat,
    output logic                       clipped
);

    localparam logic signed [ACC_W-1:0] LIM_HI = ACC_W'(MAX_VAL);
    localparam logic signed [ACC_W-1:0] LIM_LO = ACC_W'(MIN_VAL);

    always_comb begin
        clipped = 1'b0;
        sat     = acc[SAMPLE_W-1:0];
        if (acc > LIM_HI) begin
            sat     = LIM_HI[SAMPLE_W-1:0];
            clipped = 1'b1;
        end else if (acc < LIM_LO) begin
            sat     = LIM_LO[SAMPLE_W-1:0];
            clipped = 1'b1;
        end
    end

endmodule

// File: rtl/sound_mixer.sv
// Time-multiplexed voice mixer: one voice per cycle after each frame pulse, saturated 8-bit result.
module sound_mixer #(
    parameter int NUM_VOICES = 4,
    parameter int SAMPLE_W   = sound_pkg::SAMPLE_W,
    parameter int GAIN_W     = sound_pkg::GAIN_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           ready,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_data,
    input  logic [NUM_VOICES-1:0]          voice_active,
    input  logic [NUM_VOICES*GAIN_W-1:0]   voice_gain,
    input  logic                           master_mute,
    output logic [SAMPLE_W-1:0]            mix_data,
    output logic                           mix_valid,
    output logic                           busy,
    output logic                           overrun,
    output logic [15:0]                    clip_count
);
    import sound_pkg::*;

    localparam int IDX_W  = $clog2(NUM_VOICES);
    localparam int ACC_W  = SAMPLE_W + $clog2(NUM_VOICES) + 1;
    localparam int PROD_W = SAMPLE_W + GAIN_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    mix_state_t state;

    logic [NUM_VOICES*SAMPLE_W-1:0] snap_data;
    logic [NUM_VOICES-1:0]          snap_active;
    logic [NUM_VOICES*GAIN_W-1:0]   snap_gain;
    logic                           snap_mute;
    logic signed [ACC_W-1:0]        acc;
    logic [IDX_W-1:0]               idx;

    logic signed [SAMPLE_W-1:0]     cur_data;
    logic [GAIN_W-1:0]              cur_gain;
    logic signed [PROD_W-1:0]       prod;
    logic signed [ACC_W-1:0]        term;
    logic signed [SAMPLE_W-1:0]     sat;
    logic                           clipped;

    // Gain is unsigned, so it is zero-extended before the signed multiply; the
    // arithmetic shift then floors the scaled product toward negative infinity.
    always_comb begin
        cur_data = snap_data[idx*SAMPLE_W +: SAMPLE_W];
        cur_gain = snap_gain[idx*GAIN_W +: GAIN_W];
        prod     = cur_data * $signed({1'b0, cur_gain});
        term     = ACC_W'(prod >>> GAIN_W);
    end

    sound_sat #(
        .ACC_W    (ACC_W),
        .SAMPLE_W (SAMPLE_W),
        .MAX_VAL  (sample_max(SAMPLE_W)),
        .MIN_VAL  (sample_min(SAMPLE_W))
    ) u_sat (
        .acc     (acc),
        .sat     (sat),
        .clipped (clipped)
    );

    // Snapshot and accumulator are pure datapath and need no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && ready) begin
            snap_data   <= voice_data;
            snap_active <= voice_active;
            snap_gain   <= voice_gain;
            snap_mute   <= master_mute;
            acc         <= '0;
            idx         <= '0;
        end else if (state == ACCUM) begin
            if (snap_active[idx]) begin
                acc <= acc + term;
            end
            idx <= idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            mix_valid  <= 1'b0;
            mix_data   <= '0;
            overrun    <= 1'b0;
            clip_count <= '0;
        end else begin
            mix_valid <= 1'b0;
            if (ready && busy) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (ready) begin
                        busy  <= 1'b1;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (idx == LAST_IDX) begin
                        state <= OUT;
                    end
                end
                OUT: begin
                    mix_data  <= snap_mute ? '0 : sat;
                    mix_valid <= 1'b1;
                    if (clipped && clip_count != 16'hFFFF) begin
                        clip_count <= clip_count + 16'd1;
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
